inst_fetch_mem: RTL and testbench

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

---
 rtl/cpu_isa_pkg.sv | 33 +++
 rtl/inst_mem_array.sv | 36 +++
 rtl/inst_fetch_mem.sv | 80 ++++++++
 tb/tb_inst_fetch_mem.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the fetch path: major opcodes, R-type funct codes, the canonical NOP.
// No logic, so no latency.
// No handshake, so no backpressure.
package cpu_isa_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDIU = 6'h09,
        OP_ORI   = 6'h0D,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD  = 6'h20,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_e;

    // sll $0,$0,0 encodes as all-zero
    localparam logic [31:0] ISA_NOP = 32'h0000_0000;

    // Packs so that bit0 = misaligned, bit1 = out-of-range
    typedef struct packed {
        logic oor;
        logic mis;
    } fault_t;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: DEPTH x DATA_W array, one write port, one registered read port.
// Latency: read data valid 1 cycle after re; a write to the word being read returns the old word.
// Backpressure: none; rdata holds whenever re is low.
module inst_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: valid/ready fetch port, fault checks, program-load port, fetch counter.
// Latency: accepted request gives a response exactly 1 cycle later; back-to-back at full rate.
// Backpressure: req_ready drops while a response is stalled; the stalled response holds stable.
module inst_fetch_mem
    import cpu_isa_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(ISA_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_inst,
    output logic [1:0]        rsp_fault,
    input  logic              rsp_ready,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [31:0]       fetch_cnt
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd4;

    fault_t            req_flt;
    fault_t            rsp_flt;
    logic              accept;
    logic              prog_ok;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        req_flt     = '0;
        req_flt.mis = |req_addr[1:0];
        req_flt.oor = 64'(req_addr) >= LIMIT;
    end

    // Misaligned or out-of-range program writes would alias real words, so drop them.
    assign prog_ok   = prog_we && (prog_addr[1:0] == 2'b00) && (64'(prog_addr) < LIMIT);

    assign req_ready = (!rsp_valid || rsp_ready) && !rst;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_flt   <= '0;
            fetch_cnt <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_flt   <= req_flt;
            fetch_cnt <= fetch_cnt + 32'd1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    inst_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (prog_ok),
        .waddr  (prog_addr[IDX_W+1:2]),
        .wdata  (prog_data),
        .re     (accept),
        .raddr  (req_addr[IDX_W+1:2]),
        .rdata  (mem_rdata)
    );

    // The array read register clears on reset, so rsp_inst reads 0 after reset.
    assign rsp_inst  = (rsp_flt.mis || rsp_flt.oor) ? NOP_WORD : mem_rdata;
    assign rsp_fault = rsp_flt;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed bench for inst_fetch_mem with a response scoreboard and a reference memory model.
module tb_inst_fetch_mem;
    import cpu_isa_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_inst;
    logic [1:0]        rsp_fault;
    logic              rsp_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [31:0]       fetch_cnt;

    inst_fetch_mem #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NOP_WORD (ISA_NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_inst  (rsp_inst),
        .rsp_fault (rsp_fault),
        .rsp_ready (rsp_ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [1:0]  fault;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic        m_vld = 1'b0;
    logic [31:0] m_cnt = 32'd0;
    logic [31:0] mmem [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic v, input logic [31:0] a);
        req_valid = v;
        req_addr  = a;
    endtask

    task automatic prog(input logic we, input logic [31:0] a, input logic [31:0] d);
        prog_we   = we;
        prog_addr = a;
        prog_data = d;
    endtask

    // Inputs are driven just after a rising edge; this checks, updates the model, then crosses one edge.
    task automatic tick();
        logic exp_rdy;
        logic acc;
        logic mis;
        logic oor;
        exp_t e;
        #1;
        exp_rdy = (!m_vld || rsp_ready) && !rst;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (m_vld) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_empty: observed rsp_valid=%0b expected no response", rsp_valid);
            end else begin
                chk("rsp_inst", 64'(rsp_inst), 64'(sb[0].inst));
                chk("rsp_fault", 64'(rsp_fault), 64'(sb[0].fault));
            end
        end
        if (rst) begin
            sb.delete();
            m_vld = 1'b0;
            m_cnt = 32'd0;
        end else begin
            if (m_vld && rsp_ready) void'(sb.pop_front());
            acc = req_valid && exp_rdy;
            if (acc) begin
                mis     = req_addr[1:0] != 2'b00;
                oor     = req_addr >= 32'(DEPTH * 4);
                e.fault = {oor, mis};
                e.inst  = (mis || oor) ? ISA_NOP : mmem[req_addr[9:2]];
                sb.push_back(e);
                m_cnt   = m_cnt + 32'd1;
                m_vld   = 1'b1;
            end else if (rsp_ready) begin
                m_vld = 1'b0;
            end
        end
        if (prog_we && prog_addr[1:0] == 2'b00 && prog_addr < 32'(DEPTH * 4))
            mmem[prog_addr[9:2]] = prog_data;
        @(posedge clk);
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(m_vld));
        chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
        rst = 1'b1;
        rsp_ready = 1'b1;
        fetch(1'b0, 32'h0);
        prog(1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;

        // Reset state; a request during reset must not be accepted
        fetch(1'b1, 32'h04);
        tick();
        tick();
        chk("rst_rsp_inst", 64'(rsp_inst), 64'h0);
        chk("rst_rsp_fault", 64'(rsp_fault), 64'h0);
        rst = 1'b0;
        fetch(1'b0, 32'h0);

        // Program load, including the last valid word
        prog(1'b1, 32'h04, 32'h00C3_0822); tick();
        prog(1'b1, 32'h08, 32'h1023_0003); tick();
        prog(1'b1, 32'h0C, 32'h0000_0000); tick();
        prog(1'b1, 32'h3FC, 32'hCAFE_F00D); tick();
        prog(1'b0, 32'h0, 32'h0);

        // Back-to-back fetches with consumer always ready
        fetch(1'b1, 32'h04); tick();
        fetch(1'b1, 32'h08); tick();
        fetch(1'b0, 32'h0);  tick();
        chk("cnt_two", 64'(fetch_cnt), 64'd2);
        tick();

        // Stall for three cycles with a program write landing meanwhile
        rsp_ready = 1'b0;
        fetch(1'b1, 32'h04); tick();
        fetch(1'b1, 32'h08);
        prog(1'b1, 32'h10, 32'hAABB_CCDD);
        tick();
        prog(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        chk("stall_req_ready", 64'(req_ready), 64'h0);
        chk("stall_inst", 64'(rsp_inst), 64'h00C3_0822);
        rsp_ready = 1'b1;
        tick();
        fetch(1'b1, 32'h10); tick();
        fetch(1'b1, 32'h3FC); tick();

        // Fault cases
        fetch(1'b1, 32'h06);  tick();
        fetch(1'b1, 32'h400); tick();
        fetch(1'b1, 32'h402); tick();
        fetch(1'b0, 32'h0);   tick();
        chk("fault_last", 64'(rsp_fault), 64'h3);

        // Read-before-write on the same word, then refetch
        fetch(1'b1, 32'h0C);
        prog(1'b1, 32'h0C, 32'h3444_0008);
        tick();
        prog(1'b0, 32'h0, 32'h0);
        tick();
        // Misaligned and out-of-range program writes must not touch word 3
        fetch(1'b0, 32'h0);
        prog(1'b1, 32'h0E, 32'hDEAD_0001); tick();
        prog(1'b1, 32'h40C, 32'hBEEF_0002); tick();
        prog(1'b0, 32'h0, 32'h0);
        fetch(1'b1, 32'h0C); tick();
        fetch(1'b0, 32'h0);  tick();
        chk("wr_ignored", 64'(rsp_inst), 64'h3444_0008);

        // Reset while a response is stalled
        rsp_ready = 1'b0;
        fetch(1'b1, 32'h08); tick();
        fetch(1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        chk("rst_stall_vld", 64'(rsp_valid), 64'h0);
        chk("rst_stall_cnt", 64'(fetch_cnt), 64'h0);
        fetch(1'b1, 32'h04); tick();
        fetch(1'b0, 32'h0);  tick();

        // Counter wrap from a preloaded all-ones value
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        m_cnt = 32'hFFFF_FFFF;
        chk("cnt_preload", 64'(fetch_cnt), 64'hFFFF_FFFF);
        fetch(1'b1, 32'h08); tick();
        chk("cnt_wrap", 64'(fetch_cnt), 64'h0);
        fetch(1'b0, 32'h0);  tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
